// File: rtl/mem_byte_master_pkg.sv
// Shared types and funct3 decoding for the byte-wide memory master.
// No logic here beyond the funct3 to byte-count mapping.
package mem_byte_master_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DREAD  = 3'd2,
      DWRITE = 3'd3,
      DONE   = 3'd4
   } state_e;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // Zero marks an illegal funct3 for the given access direction.
   function automatic logic [2:0] f3_nbytes(input logic [2:0] f3, input logic is_store);
      logic [2:0] n;
      n = 3'd0;
      case (f3)
         3'b000:  n = 3'd1;
         3'b001:  n = 3'd2;
         3'b010:  n = 3'd4;
         3'b100:  n = is_store ? 3'd0 : 3'd1;
         3'b101:  n = is_store ? 3'd0 : 3'd2;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_byte_master_byte_assembler.sv
// Little-endian byte collector shared by fetch and load paths; word_o/ext_o
// include the byte being captured this cycle so completion needs no extra stage.
module byte_assembler
   import mem_byte_master_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        cap_i,
   input  logic [7:0]  byte_i,
   input  logic [2:0]  nbytes_i,
   input  logic        unsigned_i,
   output logic [2:0]  cnt_o,
   output logic [31:0] word_o,
   output logic [31:0] ext_o
);

   logic [31:0] word_q, word_d;
   logic [2:0]  cnt_q, cnt_d;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         word_d = '0;
         cnt_d  = 3'd0;
      end else if (cap_i) begin
         word_d[{cnt_q[1:0], 3'b000} +: 8] = byte_i;
         cnt_d = cnt_q + 3'd1;
      end
   end

   always_comb begin
      ext_o = word_d;
      case (nbytes_i)
         3'd1:    ext_o = unsigned_i ? {24'd0, word_d[7:0]}  : {{24{word_d[7]}},  word_d[7:0]};
         3'd2:    ext_o = unsigned_i ? {16'd0, word_d[15:0]} : {{16{word_d[15]}}, word_d[15:0]};
         default: ext_o = word_d;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_q <= '0;
         cnt_q  <= 3'd0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign word_o = word_d;

endmodule

// File: rtl/mem_byte_master.sv
// Sole initiator on the byte memory port: turns fetch and load/store requests into byte strobes.
// Requests are held by the requester until the one-cycle ready; data wins over fetch in IDLE.
module mem_byte_master
   import mem_byte_master_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [31:0]       if_instr,
   output logic              if_len,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [2:0]        d_func3,
   input  logic [31:0]       d_wdata,
   output logic              d_ready,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   state_e            state_q;
   logic              err_q;
   logic              uns_q;
   logic [2:0]        n_q;
   logic [2:0]        iss_q;
   logic [31:0]       wdata_q;
   logic              cap_vld_q;

   logic              if_ready_q, if_len_q, d_ready_q, d_err_q, busy_q;
   logic [31:0]       if_instr_q, d_rdata_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_re_q, mem_we_q;
   logic [7:0]        mem_wdata_q;

   logic [2:0]        d_n;
   logic              accept;
   logic              fetch_ext;
   logic              last_cap;
   logic [2:0]        n_eff;
   logic [2:0]        asm_cnt;
   logic [31:0]       asm_word, asm_ext;
   logic [ADDR_W-1:0] mem_addr_d;

   assign d_n        = f3_nbytes(d_func3, d_we);
   assign accept     = (state_q == IDLE) && (d_req || if_req);
   // Byte a is decoded as it arrives so byte a+2 can be issued on the very next cycle.
   assign fetch_ext  = (state_q == FETCH) && cap_vld_q && (asm_cnt == 3'd0) &&
                       (mem_rdata[1:0] == 2'b11);
   assign n_eff      = fetch_ext ? 3'd4 : n_q;
   assign last_cap   = cap_vld_q && (asm_cnt == n_eff - 3'd1);
   assign mem_addr_d = mem_addr_q + ADDR_W'(1);

   byte_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (accept),
      .cap_i      (cap_vld_q),
      .byte_i     (mem_rdata),
      .nbytes_i   (n_eff),
      .unsigned_i (uns_q),
      .cnt_o      (asm_cnt),
      .word_o     (asm_word),
      .ext_o      (asm_ext)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         err_q       <= 1'b0;
         uns_q       <= 1'b0;
         n_q         <= 3'd0;
         iss_q       <= 3'd0;
         wdata_q     <= '0;
         cap_vld_q   <= 1'b0;
         if_ready_q  <= 1'b0;
         if_instr_q  <= '0;
         if_len_q    <= 1'b0;
         d_ready_q   <= 1'b0;
         d_rdata_q   <= '0;
         d_err_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
         d_err_q    <= 1'b0;
         cap_vld_q  <= mem_re_q;
         unique case (state_q)
            IDLE: begin
               if (d_req) begin
                  busy_q  <= 1'b1;
                  uns_q   <= d_func3[2];
                  wdata_q <= d_wdata;
                  n_q     <= d_n;
                  err_q   <= (d_n == 3'd0);
                  state_q <= d_we ? DWRITE : DREAD;
                  if (d_n != 3'd0) begin
                     iss_q      <= 3'd1;
                     mem_addr_q <= d_addr;
                     if (d_we) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= d_wdata[7:0];
                     end else begin
                        mem_re_q <= 1'b1;
                     end
                  end
               end else if (if_req) begin
                  busy_q     <= 1'b1;
                  uns_q      <= 1'b0;
                  n_q        <= 3'd2;
                  err_q      <= 1'b0;
                  iss_q      <= 3'd1;
                  mem_addr_q <= if_addr;
                  mem_re_q   <= 1'b1;
                  state_q    <= FETCH;
               end
            end
            FETCH, DREAD: begin
               if (err_q) begin
                  state_q   <= DONE;
                  d_ready_q <= 1'b1;
                  d_err_q   <= 1'b1;
                  d_rdata_q <= '0;
               end else begin
                  if (iss_q < n_eff) begin
                     mem_re_q   <= 1'b1;
                     mem_addr_q <= mem_addr_d;
                     iss_q      <= iss_q + 3'd1;
                  end else begin
                     mem_re_q <= 1'b0;
                  end
                  if (fetch_ext)
                     n_q <= 3'd4;
                  if (last_cap) begin
                     state_q <= DONE;
                     if (state_q == FETCH) begin
                        if_ready_q <= 1'b1;
                        if_instr_q <= asm_word;
                        if_len_q   <= (n_eff == 3'd4);
                     end else begin
                        d_ready_q <= 1'b1;
                        d_rdata_q <= asm_ext;
                     end
                  end
               end
            end
            DWRITE: begin
               if (err_q) begin
                  state_q   <= DONE;
                  d_ready_q <= 1'b1;
                  d_err_q   <= 1'b1;
                  d_rdata_q <= '0;
               end else if (iss_q < n_q) begin
                  mem_addr_q  <= mem_addr_d;
                  mem_wdata_q <= wdata_q[{iss_q[1:0], 3'b000} +: 8];
                  iss_q       <= iss_q + 3'd1;
               end else begin
                  mem_we_q  <= 1'b0;
                  state_q   <= DONE;
                  d_ready_q <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_ready  = if_ready_q;
   assign if_instr  = if_instr_q;
   assign if_len    = if_len_q;
   assign d_ready   = d_ready_q;
   assign d_rdata   = d_rdata_q;
   assign d_err     = d_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_byte_master.sv
// Directed bench for mem_byte_master with a synchronous-read byte memory model.
module tb_mem_byte_master;

   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_ready;
   logic [31:0]   if_instr;
   logic          if_len;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [2:0]    d_func3;
   logic [31:0]   d_wdata;
   logic          d_ready;
   logic [31:0]   d_rdata;
   logic          d_err;
   logic [AW-1:0] mem_addr;
   logic          mem_re;
   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;
   logic          busy;

   logic [7:0]    mem [0:(1<<AW)-1];
   logic          tb_wr;
   logic [AW-1:0] tb_waddr;
   logic [7:0]    tb_wdat;

   int n_chk  = 0;
   int n_fail = 0;

   int            r_cyc, r_nre, r_nwe, r_both;
   logic [31:0]   r_data;
   logic          r_err;
   logic [AW-1:0] r_addr [0:7];
   logic [7:0]    r_wdat [0:7];

   always #5 clk = ~clk;

   mem_byte_master #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ready  (if_ready),
      .if_instr  (if_instr),
      .if_len    (if_len),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_func3   (d_func3),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready),
      .d_rdata   (d_rdata),
      .d_err     (d_err),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always @(posedge clk) begin
      if (mem_we)
         mem[mem_addr] <= mem_wdata;
      else if (tb_wr)
         mem[tb_waddr] <= tb_wdat;
      if (mem_re)
         mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [7:0] v);
      tb_wr    = 1'b1;
      tb_waddr = a;
      tb_wdat  = v;
      @(posedge clk);
      #1;
      tb_wr = 1'b0;
   endtask

   task automatic note_strobes();
      if (mem_re && mem_we) r_both++;
      if (mem_re) begin
         if (r_nre < 8) r_addr[r_nre] = mem_addr;
         r_nre++;
      end
      if (mem_we) begin
         if (r_nwe < 8) begin
            r_addr[r_nwe] = mem_addr;
            r_wdat[r_nwe] = mem_wdata;
         end
         r_nwe++;
      end
   endtask

   // Called #1 after a rising edge with the FSM idle; that cycle is cycle 0.
   task automatic run_data(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                           input logic [31:0] wd);
      r_cyc = -1; r_nre = 0; r_nwe = 0; r_both = 0; r_data = '0; r_err = 1'b0;
      d_req = 1'b1; d_we = we; d_func3 = f3; d_addr = a; d_wdata = wd;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         note_strobes();
         if (d_ready) begin
            r_cyc = c; r_data = d_rdata; r_err = d_err; d_req = 1'b0;
         end
         @(posedge clk);
         #1;
         if (r_cyc >= 0) break;
      end
      d_req = 1'b0;
   endtask

   task automatic run_fetch(input logic [AW-1:0] a);
      r_cyc = -1; r_nre = 0; r_nwe = 0; r_both = 0; r_data = '0; r_err = 1'b0;
      if_req = 1'b1; if_addr = a;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         note_strobes();
         if (if_ready) begin
            r_cyc = c; r_data = if_instr; r_err = if_len; if_req = 1'b0;
         end
         @(posedge clk);
         #1;
         if (r_cyc >= 0) break;
      end
      if_req = 1'b0;
   endtask

   initial begin
      int dc, ic, nrdy;
      logic [31:0] dd, fi;
      rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_func3 = '0; d_wdata = '0; tb_wr = 1'b0; tb_waddr = '0; tb_wdat = '0;
      @(posedge clk);
      #1;
      poke(12'h400, 8'h80); poke(12'h401, 8'h01); poke(12'h402, 8'h00); poke(12'h403, 8'h00);
      poke(12'h000, 8'h01); poke(12'h001, 8'h45); poke(12'h002, 8'h77); poke(12'h003, 8'h88);
      poke(12'h004, 8'h93); poke(12'h005, 8'h00); poke(12'h006, 8'h10); poke(12'h007, 8'h00);
      poke(12'h100, 8'h00); poke(12'h101, 8'h00); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
      check("reset_outputs", {31'd0, |{if_ready, if_instr, if_len, d_ready, d_rdata, d_err,
                                      mem_addr, mem_re, mem_we, mem_wdata, busy}}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      run_data(1'b0, 3'b000, 12'h400, '0);
      check("lb_cycle", r_cyc, 3);
      check("lb_data", r_data, 32'hFFFFFF80);
      check("lb_err", {31'd0, r_err}, 0);
      check("lb_nre", r_nre, 1);

      run_data(1'b0, 3'b100, 12'h400, '0);
      check("lbu_data", r_data, 32'h00000080);
      check("lbu_cycle", r_cyc, 3);

      run_data(1'b0, 3'b010, 12'h400, '0);
      check("lw_cycle", r_cyc, 6);
      check("lw_data", r_data, 32'h00000180);
      check("lw_nre", r_nre, 4);
      check("lw_addr3", {20'd0, r_addr[3]}, 32'h403);

      run_fetch(12'h000);
      check("fc_nre", r_nre, 2);
      check("fc_instr", r_data, 32'h00004501);
      check("fc_len", {31'd0, r_err}, 0);
      check("fc_cycle", r_cyc, 4);

      run_fetch(12'h004);
      check("f32_nre", r_nre, 4);
      check("f32_instr", r_data, 32'h00100093);
      check("f32_len", {31'd0, r_err}, 1);
      check("f32_cycle", r_cyc, 6);

      // Simultaneous requests: lb goes first, fetch starts the cycle after DONE.
      dc = -1; ic = -1; dd = '0; fi = '0;
      d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b000; d_addr = 12'h400;
      if_req = 1'b1; if_addr = 12'h000;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (d_ready) begin dc = c; dd = d_rdata; d_req = 1'b0; end
         if (if_ready) begin ic = c; fi = if_instr; if_req = 1'b0; end
         @(posedge clk);
         #1;
         if (ic >= 0) break;
      end
      d_req = 1'b0; if_req = 1'b0;
      check("arb_d_cycle", dc, 3);
      check("arb_d_data", dd, 32'hFFFFFF80);
      check("arb_if_cycle", ic, 8);
      check("arb_if_instr", fi, 32'h00004501);

      run_data(1'b1, 3'b001, 12'hFFF, 32'hA5B6C7D8);
      check("sh_cycle", r_cyc, 3);
      check("sh_nwe", r_nwe, 2);
      check("sh_nre", r_nre, 0);
      check("sh_addr0", {20'd0, r_addr[0]}, 32'hFFF);
      check("sh_addr1", {20'd0, r_addr[1]}, 32'h000);
      check("sh_dat0", {24'd0, r_wdat[0]}, 32'hD8);
      check("sh_dat1", {24'd0, r_wdat[1]}, 32'hC7);

      run_data(1'b0, 3'b001, 12'hFFF, '0);
      check("lh_wrap_cycle", r_cyc, 4);
      check("lh_wrap_data", r_data, 32'hFFFFC7D8);
      run_data(1'b0, 3'b101, 12'hFFF, '0);
      check("lhu_wrap_data", r_data, 32'h0000C7D8);

      run_data(1'b0, 3'b011, 12'h400, '0);
      check("ill_ld_cycle", r_cyc, 2);
      check("ill_ld_strobes", r_nre + r_nwe, 0);
      check("ill_ld_err", {31'd0, r_err}, 1);
      check("ill_ld_data", r_data, 32'd0);

      run_data(1'b1, 3'b100, 12'h400, 32'h12345678);
      check("ill_st_cycle", r_cyc, 2);
      check("ill_st_nwe", r_nwe, 0);
      check("ill_st_err", {31'd0, r_err}, 1);

      // sw at 0x100 interrupted by reset during cycle 3.
      r_nre = 0; r_nwe = 0; r_both = 0;
      d_req = 1'b1; d_we = 1'b1; d_func3 = 3'b010; d_addr = 12'h100; d_wdata = 32'h11223344;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0; d_req = 1'b0;
      #1;
      check("rst_mid_outputs", {31'd0, |{if_ready, if_instr, if_len, d_ready, d_rdata, d_err,
                                        mem_addr, mem_re, mem_we, mem_wdata, busy}}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      nrdy = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (d_ready || if_ready || busy) nrdy++;
         @(posedge clk); #1;
      end
      check("rst_mid_quiet", nrdy, 0);
      check("rst_mid_b0", {24'd0, mem[12'h100]}, 32'h44);
      check("rst_mid_b1", {24'd0, mem[12'h101]}, 32'h33);
      check("rst_mid_b2", {24'd0, mem[12'h102]}, 32'h00);

      run_data(1'b0, 3'b000, 12'h400, '0);
      check("post_rst_lb_cycle", r_cyc, 3);
      check("post_rst_lb_data", r_data, 32'hFFFFFF80);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   always @(negedge clk) begin
      if (rst && mem_re && mem_we) begin
         n_chk++;
         n_fail++;
         $display("FAIL re_we_overlap: mem_re=%0b mem_we=%0b required not both", mem_re, mem_we);
      end
   end

endmodule
